// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// ID-stage hazard controller for the 5-stage MIPS pipeline. A per-register
// countdown scoreboard detects RAW hazards for any forwarding depth, a flush
// counter stretches the IF/ID squash after taken branches, a two-state miss
// FSM freezes the pipe during cache fills (with a sticky timeout flag), and a
// saturating counter accumulates lost cycles. Hazard outputs are combinational
// so they act in the same cycle the hazard is visible in ID.
module hazard_scoreboard #(
    parameter int NREG         = 32,
    parameter int RW           = 5,
    parameter int ALU_WAIT     = 0,
    parameter int LOAD_WAIT    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_regwen,
    input  logic          id_memread,
    input  logic          br_taken,
    input  logic          mem_miss,
    input  logic          mem_ack,
    output logic          stall,
    output logic          flush_if,
    output logic          freeze,
    output logic [1:0]    haz_type,
    output logic          miss_err,
    output logic [31:0]   stall_cycles
);

    // Counter widths: each must hold its largest load value, and never be 0 bits.
    localparam int MAX_WAIT = (ALU_WAIT > LOAD_WAIT) ? ALU_WAIT : LOAD_WAIT;
    localparam int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int FW       = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam int TW       = (MISS_TIMEOUT < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);

    localparam logic [CW-1:0] ALU_LOAD   = CW'(ALU_WAIT);
    localparam logic [CW-1:0] LOAD_LOAD  = CW'(LOAD_WAIT);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_V  = TW'(MISS_TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(MISS_TIMEOUT - 1);

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_MISS = 1'b1
    } miss_state_t;

    // Scoreboard state: entry 0 exists only to keep indexing simple; it stays 0.
    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    logic [FW-1:0] fcnt_q, fcnt_d;
    miss_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          miss_err_q, miss_err_d;
    logic [31:0]   stall_cycles_q, stall_cycles_d;

    // Ungated hazard terms; outputs below additionally force 0 while in reset.
    logic          rs_busy, rt_busy, raw_stall;
    logic          freeze_c, flush_c, stall_c;
    logic          issue;
    logic [CW-1:0] load_val;

    // Look up the scoreboard for both ID sources; $0 is skipped by the loop bounds.
    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if ((id_rs == RW'(i)) && (cnt_q[i] != '0)) rs_busy = 1'b1;
            if ((id_rt == RW'(i)) && (cnt_q[i] != '0)) rt_busy = 1'b1;
        end
        raw_stall = id_valid & ((id_use_rs & rs_busy) | (id_use_rt & rt_busy));
    end

    // Resolve priority freeze > flush > stall and decide whether ID issues.
    always_comb begin
        freeze_c = mem_miss | (state_q == MS_MISS);
        flush_c  = br_taken | (fcnt_q != '0);
        stall_c  = raw_stall & ~freeze_c & ~flush_c;
        issue    = id_valid & id_regwen & (id_rd != '0) & ~stall_c & ~freeze_c;
        load_val = id_memread ? LOAD_LOAD : ALU_LOAD;
    end

    // Scoreboard next state: count down unless frozen; an issue load wins over the decrement.
    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!freeze_c && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - CW'(1);
            if (issue && (id_rd == RW'(i)))    cnt_d[i] = load_val;
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flush counter next state: every taken branch restarts the window; holds while frozen.
    always_comb begin
        fcnt_d = fcnt_q;
        if (br_taken) begin
            fcnt_d = FLUSH_LOAD;
        end else if ((fcnt_q != '0) && !freeze_c) begin
            fcnt_d = fcnt_q - FW'(1);
        end
    end

    // Flush counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end

    // Miss FSM next state: timer runs only while a fill is outstanding, error is sticky.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        miss_err_d = miss_err_q;
        case (state_q)
            MS_IDLE: begin
                timer_d = '0;
                if (mem_miss) state_d = MS_MISS;
            end
            MS_MISS: begin
                if (timer_q != TIMEOUT_V) timer_d = timer_q + TW'(1);
                if (timer_q >= TIMEOUT_M1) miss_err_d = 1'b1;
                if (mem_ack) begin
                    state_d = MS_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = MS_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Miss FSM registers: state, timeout timer and the registered error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MS_IDLE;
            timer_q    <= '0;
            miss_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            miss_err_q <= miss_err_d;
        end
    end

    // Lost-cycle counter next state, saturating at all ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall_c | freeze_c) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Lost-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    // Outputs: hazard enables are held low while reset is asserted.
    assign freeze       = rst_n & freeze_c;
    assign flush_if     = rst_n & flush_c;
    assign stall        = rst_n & stall_c;
    assign miss_err     = miss_err_q;
    assign stall_cycles = stall_cycles_q;

    // Two-bit hazard type reported to the existing pipeline.
    always_comb begin
        if (freeze)        haz_type = 2'b11;
        else if (flush_if) haz_type = 2'b10;
        else if (stall)    haz_type = 2'b01;
        else               haz_type = 2'b00;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed scenarios plus randomized traffic for hazard_scoreboard. Every cycle
// the outputs are compared with a reference model that tracks, per register,
// the unfrozen-cycle time at which it becomes ready, and the unfrozen-cycle time
// at which the current flush window ends.
module tb_hazard_scoreboard;

    localparam int unsigned AW = 2;
    localparam int unsigned LW = 1;
    localparam int unsigned FC = 2;
    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_regwen, id_memread;
    logic        br_taken, mem_miss, mem_ack;
    logic        stall, flush_if, freeze, miss_err;
    logic [1:0]  haz_type;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_anow;
    int unsigned m_ready [32];
    int unsigned m_fend;
    bit          m_inmiss;
    int unsigned m_missn;
    bit          m_err;
    logic [31:0] m_scnt;
    bit          e_stall, e_flush, e_freeze;
    logic [1:0]  e_ht;

    // Outputs observed in the most recent cycle
    logic        obs_stall, obs_flush, obs_freeze;
    logic [1:0]  obs_ht;

    hazard_scoreboard #(
        .NREG(32), .RW(5), .ALU_WAIT(AW), .LOAD_WAIT(LW),
        .FLUSH_CYCLES(FC), .MISS_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rd(id_rd), .id_regwen(id_regwen), .id_memread(id_memread),
        .br_taken(br_taken), .mem_miss(mem_miss), .mem_ack(mem_ack),
        .stall(stall), .flush_if(flush_if), .freeze(freeze), .haz_type(haz_type),
        .miss_err(miss_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_anow = 0;
        for (int i = 0; i < 32; i++) m_ready[i] = 0;
        m_fend   = 0;
        m_inmiss = 1'b0;
        m_missn  = 0;
        m_err    = 1'b0;
        m_scnt   = 32'd0;
    endtask

    task automatic model_eval();
        bit rsb, rtb;
        rsb      = id_use_rs && (id_rs != '0) && (m_anow < m_ready[id_rs]);
        rtb      = id_use_rt && (id_rt != '0) && (m_anow < m_ready[id_rt]);
        e_freeze = rst_n && (mem_miss || m_inmiss);
        e_flush  = rst_n && (br_taken || (m_anow < m_fend));
        e_stall  = rst_n && id_valid && (rsb || rtb) && !e_freeze && !e_flush;
        e_ht     = e_freeze ? 2'b11 : e_flush ? 2'b10 : e_stall ? 2'b01 : 2'b00;
    endtask

    task automatic model_edge();
        int unsigned a_after;
        a_after = m_anow + (e_freeze ? 0 : 1);
        if (id_valid && id_regwen && (id_rd != '0) && !e_stall && !e_freeze)
            m_ready[id_rd] = a_after + (id_memread ? LW : AW);
        if (br_taken) m_fend = a_after + FC - 1;
        if (m_inmiss) begin
            m_missn++;
            if (m_missn >= TO) m_err = 1'b1;
            if (mem_ack) begin
                m_inmiss = 1'b0;
                m_missn  = 0;
            end
        end else if (mem_miss) begin
            m_inmiss = 1'b1;
            m_missn  = 0;
        end
        if ((e_stall || e_freeze) && (m_scnt != 32'hFFFF_FFFF)) m_scnt = m_scnt + 32'd1;
        m_anow = a_after;
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic cyc();
        #2;
        model_eval();
        chk("stall",        32'(stall),    32'(e_stall));
        chk("flush_if",     32'(flush_if), 32'(e_flush));
        chk("freeze",       32'(freeze),   32'(e_freeze));
        chk("haz_type",     32'(haz_type), 32'(e_ht));
        chk("miss_err",     32'(miss_err), 32'(m_err));
        chk("stall_cycles", stall_cycles,  m_scnt);
        obs_stall  = stall;
        obs_flush  = flush_if;
        obs_freeze = freeze;
        obs_ht     = haz_type;
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rt      = '0;
        id_use_rs  = 1'b0;
        id_use_rt  = 1'b0;
        id_rd      = '0;
        id_regwen  = 1'b0;
        id_memread = 1'b0;
    endtask

    task automatic clear_inputs();
        idle();
        br_taken = 1'b0;
        mem_miss = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic set_instr(input int rs, input int rt, input bit urs, input bit urt,
                             input int rd, input bit wen, input bit mem);
        id_valid   = 1'b1;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_rd      = 5'(rd);
        id_regwen  = wen;
        id_memread = mem;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must drop at once.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_stall",        32'(stall),    32'd0);
        chk("rst_flush_if",     32'(flush_if), 32'd0);
        chk("rst_freeze",       32'(freeze),   32'd0);
        chk("rst_haz_type",     32'(haz_type), 32'd0);
        chk("rst_miss_err",     32'(miss_err), 32'd0);
        chk("rst_stall_cycles", stall_cycles,  32'd0);
        model_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
    endtask

    // Hold the current ID instruction until it issues; return stall cycles seen.
    task automatic issue_count(output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        for (int k = 0; (k < 20) && !done; k++) begin
            cyc();
            if (obs_stall)        n++;
            else if (!obs_freeze) done = 1'b1;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    // Count cycles with flush_if high, driving br_taken for the first two cycles.
    task automatic flush_run(input bit b0, input bit b1, output int n);
        bit done;
        n = 0;
        br_taken = b0;
        cyc();
        if (obs_flush) n++;
        if (obs_flush) chk("flush_ht", 32'(obs_ht), 32'd2);
        br_taken = b1;
        cyc();
        if (obs_flush) n++;
        br_taken = 1'b0;
        done = 1'b0;
        for (int k = 0; (k < 10) && !done; k++) begin
            cyc();
            if (obs_flush) n++;
            else           done = 1'b1;
        end
        if (!done) chk("flush_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use: one stall cycle with haz_type 01, then an independent op never stalls.
        set_instr(0, 0, 0, 0, 2, 1, 1);
        issue_count(n);
        set_instr(2, 4, 1, 1, 3, 1, 0);
        #1 chk("load_use_ht", 32'(haz_type), 32'd1);
        issue_count(n);
        chk("load_use_stalls", 32'(n), 32'd1);
        set_instr(6, 7, 1, 1, 5, 1, 0);
        issue_count(n);
        chk("indep_stalls", 32'(n), 32'd0);

        // ALU producer with a 2-cycle wait: back-to-back, one gap, and $0.
        set_instr(0, 0, 0, 0, 8, 1, 0);
        issue_count(n);
        set_instr(8, 0, 1, 0, 14, 1, 0);
        issue_count(n);
        chk("alu_b2b_stalls", 32'(n), 32'd2);
        set_instr(0, 0, 0, 0, 9, 1, 0);
        issue_count(n);
        set_instr(11, 12, 1, 1, 10, 1, 0);
        issue_count(n);
        set_instr(9, 9, 1, 1, 15, 1, 0);
        issue_count(n);
        chk("alu_gap1_stalls", 32'(n), 32'd1);
        set_instr(0, 0, 0, 0, 0, 1, 1);
        issue_count(n);
        set_instr(0, 0, 1, 1, 16, 1, 0);
        issue_count(n);
        chk("reg0_stalls", 32'(n), 32'd0);
        set_instr(17, 0, 1, 0, 17, 1, 0);
        issue_count(n);
        set_instr(17, 0, 1, 0, 17, 1, 0);
        issue_count(n);
        chk("self_dep_stalls", 32'(n), 32'd2);
        idle();

        // Flush window: one branch gives 2 cycles, a second in cycle 2 gives 3.
        flush_run(1'b1, 1'b0, n);
        chk("flush_single", 32'(n), 32'd2);
        flush_run(1'b1, 1'b1, n);
        chk("flush_double", 32'(n), 32'd3);

        // Freeze over a pending data stall: 11 throughout, then the full 2 stalls resume.
        set_instr(0, 0, 0, 0, 13, 1, 0);
        issue_count(n);
        set_instr(13, 0, 1, 0, 18, 1, 0);
        mem_miss = 1'b1;
        cyc();
        chk("frz_ht0", 32'(obs_ht), 32'd3);
        mem_miss = 1'b0;
        cyc();
        chk("frz_ht1", 32'(obs_ht), 32'd3);
        cyc();
        mem_ack = 1'b1;
        cyc();
        chk("frz_ht_ack", 32'(obs_ht), 32'd3);
        mem_ack = 1'b0;
        issue_count(n);
        chk("stall_after_freeze", 32'(n), 32'd2);
        chk("no_err_short_miss", 32'(miss_err), 32'd0);
        idle();

        // Miss timeout: error after 4 cycles in MISS, sticky past mem_ack.
        mem_miss = 1'b1;
        cyc();
        mem_miss = 1'b0;
        repeat (3) cyc();
        chk("err_before_timeout", 32'(miss_err), 32'd0);
        cyc();
        chk("err_at_timeout", 32'(miss_err), 32'd1);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        cyc();
        chk("err_sticky", 32'(miss_err), 32'd1);
        chk("freeze_released", 32'(obs_freeze), 32'd0);

        // Reset in the middle of a branch, a miss and a pending hazard.
        set_instr(0, 0, 0, 0, 19, 1, 1);
        issue_count(n);
        set_instr(19, 0, 1, 0, 20, 1, 0);
        br_taken = 1'b1;
        mem_miss = 1'b1;
        do_reset();
        set_instr(19, 0, 1, 0, 20, 1, 0);
        issue_count(n);
        chk("no_stall_after_reset", 32'(n), 32'd0);
        idle();

        // Ten lost cycles accumulate to ten.
        do_reset();
        mem_miss = 1'b1;
        repeat (9) cyc();
        mem_miss = 1'b0;
        mem_ack  = 1'b1;
        cyc();
        mem_ack = 1'b0;
        cyc();
        chk("stall_cycles_10", stall_cycles, 32'd10);

        // Saturation of the lost-cycle counter from a preset value.
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        m_scnt = 32'hFFFF_FFFD;
        #1 release dut.stall_cycles_q;
        mem_miss = 1'b1;
        repeat (5) cyc();
        mem_miss = 1'b0;
        mem_ack  = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("stall_cycles_sat", stall_cycles, 32'hFFFF_FFFF);
        do_reset();

        // Randomized traffic against the model; stalled instructions usually stay in ID.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end
            if (!(obs_stall || obs_freeze) || ($urandom_range(0, 7) == 0)) begin
                id_valid   = ($urandom_range(0, 7) != 0);
                id_rs      = 5'($urandom_range(0, 7));
                id_rt      = 5'($urandom_range(0, 7));
                id_use_rs  = 1'($urandom_range(0, 1));
                id_use_rt  = 1'($urandom_range(0, 1));
                id_rd      = 5'($urandom_range(0, 7));
                id_regwen  = ($urandom_range(0, 3) != 0);
                id_memread = ($urandom_range(0, 2) == 0);
            end
            br_taken = ($urandom_range(0, 11) == 0);
            mem_miss = ($urandom_range(0, 15) == 0);
            mem_ack  = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
